// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: keyboard command/response bytes and the host
// transmitter state encoding.
package ps2_pkg;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQUEST  = 3'd2,
    ST_XMIT     = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAITIDLE = 3'd5
  } tx_state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioner: 2-flop synchronizer, stable-sample filter and a
// one-cycle pulse on each accepted 1->0 transition.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pad};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        fall  <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command byte
// with odd parity on device clock falls, and reports the device ACK bit.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 3500,
  parameter int unsigned SETUP_CYCLES   = 28,
  parameter int unsigned TIMEOUT_CYCLES = 560000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] din,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned MAX_IS  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_IS > TIMEOUT_CYCLES) ? MAX_IS : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       BIT_STOP = 4'd9;

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bitcnt;
  logic [8:0]       sh;
  logic             ack_bit;

  logic clk_lvl, fall_clk;
  logic dat_lvl, dat_fall_unused;
  logic timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .rst   (rst),
    .pad   (ps2clk_in),
    .level (clk_lvl),
    .fall  (fall_clk)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk   (clk),
    .rst   (rst),
    .pad   (ps2dat_in),
    .level (dat_lvl),
    .fall  (dat_fall_unused)
  );

  // The counter holds at its last value so a timeout masked by a line event
  // still fires in the following state.
  assign timeout = (cnt == TO_LAST);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      sh        <= '0;
      ack_bit   <= 1'b0;
      ps2clk_oe <= 1'b0;
      ps2dat_oe <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          ps2clk_oe <= 1'b0;
          ps2dat_oe <= 1'b0;
          if (send) begin
            sh        <= {odd_parity(din), din};
            cnt       <= '0;
            ps2clk_oe <= 1'b1;
            state     <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt       <= '0;
            ps2dat_oe <= 1'b1;
            state     <= ST_REQUEST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_REQUEST: begin
          if (cnt == SET_LAST) begin
            cnt       <= '0;
            bitcnt    <= '0;
            ps2clk_oe <= 1'b0;
            state     <= ST_XMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_XMIT: begin
          cnt <= timeout ? cnt : cnt + 1'b1;
          if (fall_clk) begin
            if (bitcnt == BIT_STOP) begin
              ps2dat_oe <= 1'b0;
              state     <= ST_ACK;
            end else begin
              ps2dat_oe <= ~sh[bitcnt];
              bitcnt    <= bitcnt + 1'b1;
            end
          end else if (timeout) begin
            ps2dat_oe <= 1'b0;
            error     <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_ACK: begin
          cnt <= timeout ? cnt : cnt + 1'b1;
          if (fall_clk) begin
            ack_bit <= dat_lvl;
            state   <= ST_WAITIDLE;
          end else if (timeout) begin
            ps2dat_oe <= 1'b0;
            error     <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_WAITIDLE: begin
          cnt <= timeout ? cnt : cnt + 1'b1;
          if (clk_lvl && dat_lvl) begin
            done  <= ~ack_bit;
            error <= ack_bit;
            state <= ST_IDLE;
          end else if (timeout) begin
            ps2dat_oe <= 1'b0;
            error     <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          ps2clk_oe <= 1'b0;
          ps2dat_oe <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 keyboard model
// that clocks the frame, samples every bit and drives the ACK slot.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 3500;
  localparam int unsigned SET = 28;
  localparam int unsigned TO  = 3000;
  localparam int unsigned FL  = 8;
  localparam int unsigned H   = 40;

  logic       clk = 1'b0;
  logic       rst, send;
  logic [7:0] din;
  logic       ps2clk_in, ps2dat_in;
  logic       ps2clk_oe, ps2dat_oe, busy, done, error;
  logic       dev_clk_low, dev_dat_low, glitch;

  int checks   = 0;
  int failures = 0;

  assign ps2clk_in = ~(ps2clk_oe | dev_clk_low | glitch);
  assign ps2dat_in = ~(ps2dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .din       (din),
    .ps2clk_in (ps2clk_in),
    .ps2dat_in (ps2dat_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic [7:0] b;
    logic       par;
    logic       dev_ack;
    logic       inject;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // One device clock pulse; data is sampled as the clock is released.
  task automatic dev_pulse(input bit glitch_en, output logic s);
    dev_clk_low = 1'b1;
    cyc(H);
    dev_clk_low = 1'b0;
    s = ps2dat_in;
    if (glitch_en) begin
      cyc(H / 2 - 2);
      glitch = 1'b1;
      cyc(3);
      glitch = 1'b0;
      cyc(H / 2 - 1);
    end else begin
      cyc(H);
    end
  endtask

  task automatic start_send(input logic [7:0] b);
    send = 1'b1;
    din  = b;
    cyc(1);
    send = 1'b0;
    din  = 8'h00;
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input logic dev_ack,
                      input logic inject, input bit glitch_en, output logic [10:0] frame);
    int   n;
    logic s;
    start_send(b);
    check({tag, "_busy_after_send"}, busy, 1);
    n = 0;
    while (ps2clk_oe && !ps2dat_oe && n < INH + 10) begin
      n++;
      if (inject && n == 100) begin
        send = 1'b1;
        din  = 8'h55;
      end else begin
        send = 1'b0;
      end
      cyc(1);
    end
    send = 1'b0;
    check({tag, "_inhibit_len"}, n, INH);
    n = 0;
    while (ps2clk_oe && ps2dat_oe && n < SET + 10) begin
      n++;
      cyc(1);
    end
    check({tag, "_request_len"}, n, SET);
    check({tag, "_clk_released"}, ps2clk_oe, 0);
    cyc(20);
    frame[0] = ps2dat_in;
    for (int k = 1; k <= 10; k++) begin
      dev_pulse(glitch_en && k == 4, s);
      frame[k] = s;
      if (inject && k == 5) begin
        send = 1'b1;
        din  = 8'h55;
        cyc(1);
        send = 1'b0;
        din  = 8'h00;
      end
    end
    if (dev_ack) dev_dat_low = 1'b1;
    cyc(H / 2);
    dev_clk_low = 1'b1;
    cyc(H);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input logic exp_done, input logic exp_err);
    int n;
    int extra;
    n = 0;
    while (!(done || error) && n < 600) begin
      n++;
      cyc(1);
    end
    check({tag, "_result_seen"}, (n < 600), 1);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy_at_end"}, busy, 0);
    check({tag, "_lines_released"}, {ps2clk_oe, ps2dat_oe}, 0);
    cyc(1);
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      if (done || error || ps2clk_oe || busy) extra++;
      cyc(1);
    end
    check({tag, "_quiet_after"}, extra, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [10:0] frame;
    int          n;
    logic        s;

    vecs[0] = '{b: CMD_SET_LEDS, par: 1'b1, dev_ack: 1'b1, inject: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{b: 8'h00,        par: 1'b1, dev_ack: 1'b1, inject: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{b: 8'h01,        par: 1'b0, dev_ack: 1'b1, inject: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{b: 8'hFF,        par: 1'b1, dev_ack: 1'b1, inject: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{b: CMD_ENABLE,   par: 1'b0, dev_ack: 1'b0, inject: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{b: CMD_ENABLE,   par: 1'b0, dev_ack: 1'b1, inject: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    glitch      = 1'b0;
    rst         = 1'b1;
    send        = 1'b1;
    din         = 8'hFF;
    cyc(4);
    rst  = 1'b0;
    send = 1'b0;
    din  = 8'h00;
    check("reset_busy", busy, 0);
    check("reset_outputs", {ps2clk_oe, ps2dat_oe, done, error}, 0);
    cyc(20);
    check("reset_send_ignored", {busy, ps2clk_oe}, 0);

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("v%0d_%02h", i, vecs[i].b);
      xfer(tag, vecs[i].b, vecs[i].dev_ack, vecs[i].inject, 1'b0, frame);
      check({tag, "_frame"}, frame, {1'b1, vecs[i].par, vecs[i].b, 1'b0});
      finish_xfer(tag, vecs[i].exp_done, vecs[i].exp_err);
    end

    // Device never clocks: error exactly TO cycles after the clock is released.
    start_send(8'h01);
    n = 0;
    while (ps2clk_oe && n < INH + SET + 100) begin
      n++;
      cyc(1);
    end
    check("to_release_seen", ps2clk_oe, 0);
    n = 0;
    while (!error && n < TO + 100) begin
      n++;
      cyc(1);
    end
    check("to_latency", n, TO);
    check("to_done_low", done, 0);
    check("to_busy", busy, 0);
    check("to_lines_released", {ps2clk_oe, ps2dat_oe}, 0);
    cyc(1);
    check("to_error_one_cycle", error, 0);

    // Reset after bit 4 of a 0xF4 transfer.
    start_send(CMD_ENABLE);
    n = 0;
    while ((ps2clk_oe || !ps2dat_oe) && n < INH + SET + 100) begin
      n++;
      cyc(1);
    end
    cyc(20);
    for (int k = 1; k <= 4; k++) dev_pulse(1'b0, s);
    check("rst_pre_dat_oe", ps2dat_oe, 1);
    rst = 1'b1;
    cyc(1);
    check("rst_mid_lines", {ps2clk_oe, ps2dat_oe}, 0);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0;
    cyc(20);

    // Fresh 0xFF after reset, with a 3-cycle clock glitch mid-frame.
    xfer("post_rst_ff", CMD_RESET, 1'b1, 1'b0, 1'b1, frame);
    check("post_rst_ff_frame", frame, {1'b1, 1'b1, 8'hFF, 1'b0});
    finish_xfer("post_rst_ff", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter.
- Sends one command byte to the keyboard, for example 0xED set-LEDs, 0xF4 enable, 0xFF reset, then checks the device's line-level ACK bit.
- Sits beside the PS/2 receiver and feeds the same open-drain clock/data pads.
- `busy` tells the receiver and scancode path to ignore the lines while a transfer is in progress.

Parameters:
- INHIBIT_CYCLES, default 3500: clock-low inhibit time (125 us at 28 MHz); minimum 100 us.
- SETUP_CYCLES, default 28: data-low setup before clock release (1 us).
- TIMEOUT_CYCLES, default 560000: maximum time from clock release to end of transfer (20 ms).
- FILTER_LEN, default 8: consecutive equal samples needed to accept a new PS/2 line level.

Ports:
- clk, in, 1: system clock (same clock as the PS/2 receiver).
- rst, in, 1: reset, synchronous, active-high.
- send, in, 1: one-cycle request; din is sampled in the same cycle.
- din, in, 8: command byte.
- ps2clk_in, in, 1: raw PS/2 clock pad level (asynchronous).
- ps2dat_in, in, 1: raw PS/2 data pad level (asynchronous).
- ps2clk_oe, out, 1: 1 = drive PS/2 clock low; 0 = release.
- ps2dat_oe, out, 1: 1 = drive PS/2 data low; 0 = release.
- busy, out, 1: high from the cycle after an accepted send until the cycle done/error pulses.
- done, out, 1: one-cycle pulse; transfer completed and device ACK bit was 0.
- error, out, 1: one-cycle pulse on NACK or timeout.

Behaviour:
- Reset values: ps2clk_oe=0, ps2dat_oe=0, busy=0, done=0, error=0; state=IDLE; counters cleared.
- rst takes priority over everything, including a simultaneous send. Reset mid-transfer releases both lines on the next edge.
- Input conditioning:
  - Each pad passes through a 2-flop synchronizer, then a FILTER_LEN stable-sample filter.
  - fall_clk = one-cycle pulse on a filtered clock 1->0 transition.
  - Filtered levels reset to 1.
- States:
  - IDLE: lines released. If send=1, latch sh = {~^din, din} (odd parity in bit 8), clear the counter, go to INHIBIT. send in any other state is ignored.
  - INHIBIT: ps2clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQUEST.
  - REQUEST: ps2clk_oe=1 and ps2dat_oe=1 (start bit) for SETUP_CYCLES cycles. Then go to XMIT, release the clock, clear bitcnt and timeout counter.
  - XMIT: ps2dat_oe held at the start level (1) until the first fall_clk.
    - On each fall_clk with bitcnt 0..8: ps2dat_oe = ~sh[bitcnt], bitcnt++.
    - On fall_clk with bitcnt=9: ps2dat_oe=0 (stop bit = 1), go to ACK.
    - The device samples each bit on the rising edge.
  - ACK: on the next fall_clk, capture filtered data (0 = ACK), go to WAITIDLE.
  - WAITIDLE: wait until filtered clock=1 and data=1. Then pulse done if ACK=0, or pulse error if ACK=1, and return to IDLE.
- Timeout:
  - The timeout counter runs through XMIT, ACK and WAITIDLE.
  - On reaching TIMEOUT_CYCLES-1: release both lines, pulse error, go to IDLE.
  - Timeout and a normal completion in the same cycle: completion wins.
- busy = (state != IDLE). done and error are never high together.
- Every data change happens only while the device holds clock low, i.e. on fall_clk.
- Counter widths are $clog2 of the largest parameter; no wrap is possible inside a state.

Decomposition:
- Shared package ps2_pkg:
  - Command constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA, RSP_RESEND=8'hFE.
  - State enum for this FSM.
- Sub-module ps2_line_filter: synchronizer + stable filter + falling-edge pulse. Used twice here (clock and data) and reusable by the receiver.
- RSP_ACK/RSP_RESEND responses are handled by the higher-level LED/command controller, not this block.

Test Plan:
- Send 0xED with a device model that ACKs:
  - ps2clk_oe low for exactly 3500 cycles, then data low 28 cycles.
  - Device samples data bits LSB-first 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device drives ACK 0 → one done pulse, busy falls the same cycle.
- Parity checks:
  - 0x00 → parity 1.
  - 0x01 → parity 0.
  - 0xFF → parity 1.
  - Model checks all 11 device-side samples.
- NACK: device leaves data high in the ACK slot → error=1 for one cycle, done stays 0, both lines released.
- Timeout: device never clocks after release → error exactly TIMEOUT_CYCLES after XMIT entry, lines released, busy=0.
- send asserted while busy with 0x55 during a 0xF4 transfer → wire carries only 0xF4, single done.
- Reset and glitches:
  - rst asserted after bit 4 → next cycle ps2clk_oe=ps2dat_oe=busy=0.
  - New 0xFF send then completes normally.
  - A 3-cycle clock glitch generates no fall_clk.
